// File: rtl/alu_share_pkg.sv
// Shared types and constants for the ALU share arbiter.
// Imported by the picker, the arbiter top and the bench.
package alu_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int FLG_INV  = 0;
  localparam int FLG_ZERO = 1;
  localparam int FLG_SIGN = 2;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;

  localparam int CNT_W = 3;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid at or above
// rr_ptr, else the lowest valid below it.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 3
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_valid
);

  always_comb begin
    grant_id    = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_valid && req_valid[i] &&
          ID_W'(i) >= rr_ptr) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'(i);
      end
    end
    // Nothing at or above the pointer: wrap to the bottom.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_valid && req_valid[i]) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one 16-bit ALU between NUM_REQ requesters,
// round-robin, returning tagged results on one channel.
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int EXEC_CYCLES = 1,
  parameter int ID_W        = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [4*NUM_REQ-1:0]    req_op,
  input  logic [16*NUM_REQ-1:0]   req_a,
  input  logic [16*NUM_REQ-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [15:0]             rsp_y,
  output logic [2:0]              rsp_flags,
  output logic [3:0]              alu_sel,
  output logic [15:0]             alu_a,
  output logic [15:0]             alu_b,
  input  logic [15:0]             alu_y,
  input  logic [2:0]              alu_flags,
  output logic                    busy
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        alu_sel_q, alu_sel_d;
  logic [15:0]       alu_a_q, alu_a_d;
  logic [15:0]       alu_b_q, alu_b_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [15:0]       rsp_y_q, rsp_y_d;
  logic [2:0]        rsp_flags_q, rsp_flags_d;

  logic [ID_W-1:0]   grant_id;
  logic              grant_valid;
  logic [3:0]        op_g;
  logic [15:0]       a_g, b_g;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_valid   (req_valid),
    .rr_ptr      (rr_ptr_q),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  always_comb begin
    op_g = '0;
    a_g  = '0;
    b_g  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        op_g = req_op[4*i +: 4];
        a_g  = req_a[16*i +: 16];
        b_g  = req_b[16*i +: 16];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state_q == IDLE) && grant_valid &&
                     (grant_id == ID_W'(i));
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    alu_sel_d   = alu_sel_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_y_d     = rsp_y_q;
    rsp_flags_d = rsp_flags_q;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          alu_sel_d = op_g;
          alu_a_d   = a_g;
          alu_b_d   = b_g;
          id_d      = grant_id;
          cnt_d     = '0;
          rr_ptr_d  = ID_W'(wrap_inc(int'(grant_id), NUM_REQ));
          state_d   = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(EXEC_CYCLES - 1)) begin
          rsp_y_d               = alu_y;
          rsp_flags_d[FLG_INV]  = alu_flags[FLG_INV];
          rsp_flags_d[FLG_ZERO] = alu_flags[FLG_ZERO];
          rsp_flags_d[FLG_SIGN] = alu_flags[FLG_SIGN];
          rsp_id_d              = id_q;
          rsp_valid_d           = 1'b1;
          state_d               = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      alu_sel_q   <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      alu_sel_q   <= alu_sel_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  assign alu_sel   = alu_sel_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_flags = rsp_flags_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: behavioural ALU stand-in,
// transaction-level reference model, directed then random steps.
module tb_alu_share_arbiter;
  import alu_share_pkg::*;

  localparam int N  = 3;
  localparam int E  = 3;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [4*N-1:0]  req_op;
  logic [16*N-1:0] req_a;
  logic [16*N-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [15:0]     rsp_y;
  logic [2:0]      rsp_flags;
  logic [3:0]      alu_sel;
  logic [15:0]     alu_a;
  logic [15:0]     alu_b;
  logic [15:0]     alu_y;
  logic [2:0]      alu_flags;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(
    .NUM_REQ     (N),
    .EXEC_CYCLES (E),
    .ID_W        (IW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_flags (rsp_flags),
    .alu_sel   (alu_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_y     (alu_y),
    .alu_flags (alu_flags),
    .busy      (busy)
  );

  // {sign, zero, invalid, y}
  function automatic logic [18:0] alu_f(input logic [3:0] op,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
    logic [15:0] y;
    logic        inv;
    y   = '0;
    inv = 1'b0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      default: inv = 1'b1;
    endcase
    return {y[15], (y == 16'h0), inv, y};
  endfunction

  assign {alu_flags, alu_y} = alu_f(alu_sel, alu_a, alu_b);

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Reference model: one transaction in flight or one response pending.
  bit          m_infl, m_pend;
  int          m_left, m_ptr, m_id, m_rid;
  logic [3:0]  m_sel;
  logic [15:0] m_a, m_b, m_ry;
  logic [2:0]  m_rf;
  logic [N-1:0] last_ready;

  task automatic model_reset();
    m_infl = 0; m_pend = 0; m_left = 0; m_ptr = 0;
    m_id = 0; m_rid = 0; m_sel = '0; m_a = '0; m_b = '0;
    m_ry = '0; m_rf = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    int g;
    logic [N-1:0] er;
    @(negedge clk);
    g  = (m_infl || m_pend) ? -1 : pick(req_valid, m_ptr);
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("onehot", 32'($countones(req_ready) <= 1), 32'd1);
    chk("busy", 32'(busy), 32'(m_infl || m_pend));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_pend));
    chk("rsp_id", 32'(rsp_id), 32'(m_rid));
    chk("rsp_y", 32'(rsp_y), 32'(m_ry));
    chk("rsp_flags", 32'(rsp_flags), 32'(m_rf));
    chk("alu_sel", 32'(alu_sel), 32'(m_sel));
    chk("alu_a", 32'(alu_a), 32'(m_a));
    chk("alu_b", 32'(alu_b), 32'(m_b));
    last_ready = req_ready;
    if (!rst_n) begin
      model_reset();
    end else if (m_pend) begin
      if (rsp_ready) m_pend = 0;
    end else if (m_infl) begin
      m_left--;
      if (m_left == 0) begin
        m_infl = 0;
        m_pend = 1;
        {m_rf, m_ry} = alu_f(m_sel, m_a, m_b);
        m_rid = m_id;
      end
    end else if (g >= 0) begin
      m_infl = 1;
      m_left = E;
      m_sel  = req_op[4*g +: 4];
      m_a    = req_a[16*g +: 16];
      m_b    = req_b[16*g +: 16];
      m_id   = g;
      m_ptr  = (g + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int id, input logic [3:0] op,
                         input logic [15:0] a, input logic [15:0] b);
    req_op[4*id +: 4]  = op;
    req_a[16*id +: 16] = a;
    req_b[16*id +: 16] = b;
  endtask

  task automatic do_op(input int id, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input int stall, output logic [15:0] y,
                       output logic [2:0] f, output int rid);
    int lat;
    logic [N-1:0] one;
    one = '0;
    one[id] = 1'b1;
    set_req(id, op, a, b);
    req_valid = one;
    rsp_ready = 1'b0;
    tick();
    chk("accept", 32'(last_ready), 32'(one));
    req_valid = '0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", lat, E);
    y   = rsp_y;
    f   = rsp_flags;
    rid = int'(rsp_id);
    req_valid = '1;
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_ready", 32'(last_ready), 32'd0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [15:0] y;
    logic [2:0]  f;
    int          rid;
    int          grants[$];
    int          t;

    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();

    // Single ADD from requester 0.
    do_op(0, ALU_ADD, 16'h1234, 16'h0001, 0, y, f, rid);
    chk("add_y", 32'(y), 32'h1235);
    chk("add_f", 32'(f), 32'h0);
    chk("add_id", rid, 0);

    // Continuous 0 and 1 after reset: 0,1,0,1.
    do_reset();
    req_valid = 3'b011;
    rsp_ready = 1'b1;
    t = 0;
    while (grants.size() < 4 && t < 60) begin
      tick();
      t++;
      for (int i = 0; i < N; i++)
        if (last_ready[i]) grants.push_back(i);
    end
    chk("rr_count", grants.size(), 4);
    for (int i = 0; i < grants.size() && i < 4; i++)
      chk("rr_order", grants[i], i % 2);
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < E + 2; i++) begin
      rsp_ready = 1'b1;
      tick();
    end
    rsp_ready = 1'b0;

    // Response stall of 5 cycles.
    do_op(2, ALU_AND, 16'hF0F0, 16'h3C3C, 5, y, f, rid);
    chk("and_y", 32'(y), 32'h3030);
    chk("and_id", rid, 2);

    // SUB zero and sign flags.
    do_op(1, ALU_SUB, 16'h0005, 16'h0005, 0, y, f, rid);
    chk("sub0_y", 32'(y), 32'h0000);
    chk("sub0_zero", 32'(f[FLG_ZERO]), 32'd1);
    do_op(1, ALU_SUB, 16'h0000, 16'h0001, 0, y, f, rid);
    chk("subn_y", 32'(y), 32'hFFFF);
    chk("subn_sign", 32'(f[FLG_SIGN]), 32'd1);

    // Invalid op is forwarded; flag comes from the ALU.
    do_op(0, 4'hF, 16'h1111, 16'h2222, 0, y, f, rid);
    chk("inv_flag", 32'(f[FLG_INV]), 32'd1);

    // Reset in the middle of EXEC.
    set_req(2, ALU_ADD, 16'h0001, 16'h0002);
    req_valid = 3'b100;
    tick();
    req_valid = '0;
    tick();
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    req_valid = 3'b011;
    tick();
    chk("rst_grant0", 32'(last_ready), 32'b001);
    req_valid = '0;

    // Random traffic.
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        logic [15:0] ra;
        ra = 16'($urandom);
        set_req(i,
                ($urandom_range(0, 7) == 0) ? 4'hF
                  : 4'($urandom_range(0, 2)),
                ra,
                ($urandom_range(0, 3) == 0) ? ra : 16'($urandom));
      end
      req_valid = N'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single 16-bit ALU between NUM_REQ requesters.
- Each requester presents an operation: 4-bit op select plus two 16-bit operands, with a valid/ready handshake.
- The block grants one requester at a time in round-robin order, drives the ALU operand/select inputs from registers, and captures the ALU result and status flags.
- It returns the result on one shared response channel tagged with the requester id. It sits between client logic and the ALU instance.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- EXEC_CYCLES, 1, cycles the ALU inputs are held stable before the result is sampled (1..7).
- ID_W, 3, width of requester id fields; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_op  in  4*NUM_REQ  per-requester ALU op select; slice i is [4i+3:4i].
- req_a  in  16*NUM_REQ  per-requester operand a.
- req_b  in  16*NUM_REQ  per-requester operand b.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_y  out  16  ALU result.
- rsp_flags  out  3  ALU status: bit0 invalid-op, bit1 zero, bit2 sign.
- alu_sel  out  4  to ALU select input, registered.
- alu_a  out  16  to ALU operand a, registered.
- alu_b  out  16  to ALU operand b, registered.
- alu_y  in  16  from ALU result.
- alu_flags  in  3  from ALU status flags.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low at posedge), values:
  - state=IDLE; rr_ptr=0, so requester 0 has highest priority.
  - alu_sel=0, alu_a=0, alu_b=0.
  - rsp_valid=0, rsp_id=0, rsp_y=0, rsp_flags=0.
  - exec counter=0.
- Reset mid-operation discards the in-flight transaction with no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant = first asserted req_valid scanning from rr_ptr upward with wrap-around.
  - req_ready[grant]=1 combinationally; all other req_ready bits are 0.
  - If any request is valid, at posedge: capture req_op/a/b[grant] into alu_sel/a/b, latch grant id, clear counter, go to EXEC.
  - rr_ptr <= grant+1, wrapping to 0 at NUM_REQ.
  - No valid request: stay in IDLE; req_ready all 0.
- EXEC:
  - ALU inputs are held stable; counter increments each cycle.
  - When counter==EXEC_CYCLES-1: rsp_y<=alu_y, rsp_flags<=alu_flags, rsp_id<=latched id, rsp_valid<=1, go to RESP.
- RESP:
  - rsp_valid and the rsp_* outputs are held until rsp_valid & rsp_ready at posedge.
  - On handshake: rsp_valid<=0, go to IDLE.
  - No new request is accepted in RESP.
- req_ready is 0 in EXEC and RESP.
- Latency: accept at edge N, rsp_valid high after edge N+EXEC_CYCLES, earliest consume at edge N+EXEC_CYCLES+1.
- Peak throughput is one operation per EXEC_CYCLES+2 cycles.
- Requesters must not make req_valid depend on req_ready. Operands need to be stable only in the accept cycle.
- Dropping req_valid before grant is legal; no transaction occurs.
- Invalid op codes are forwarded unchanged; the invalid-op flag comes from the ALU. The arbiter never filters them.
- alu_sel/alu_a/alu_b keep their last values in IDLE; they are not cleared.
- busy = (state != IDLE).

Decomposition:
- Package alu_share_pkg holds:
  - state enum (IDLE=2'd0, EXEC=2'd1, RESP=2'd2);
  - flag bit indices FLG_INV=0, FLG_ZERO=1, FLG_SIGN=2;
  - op constants ALU_ADD=4'h0, ALU_SUB=4'h1, ALU_AND=4'h2.
- One sub-module, rr_pick: combinational round-robin picker taking (req_valid, rr_ptr) and producing (grant_id, grant_valid). It is parameterized by NUM_REQ and ID_W and is testable standalone.

Test Plan:
- Single op, requester 0 ALU_ADD a=16'h1234 b=16'h0001 -> req_ready[0] pulses one cycle; rsp_valid at accept+EXEC_CYCLES; rsp_id=0, rsp_y=16'h1235, rsp_flags=3'b000.
- Both requesters valid continuously after reset -> grant order 0,1,0,1; req_ready never asserted for two requesters in the same cycle.
- rsp_ready held low 5 cycles in RESP -> rsp_valid/rsp_y/rsp_id stable all 5 cycles; req_ready stays 0; one response only after rsp_ready rises.
- Requester 1 ALU_SUB a=16'h0005 b=16'h0005 -> rsp_y=16'h0000, rsp_flags[1]=1; a=16'h0000 b=16'h0001 -> rsp_y=16'hFFFF, rsp_flags[2]=1.
- rst_n low during EXEC -> next cycle state IDLE, rsp_valid=0, rr_ptr=0; a valid requester 0 is granted on the first cycle after reset release.
- EXEC_CYCLES=3 build -> rsp_valid rises exactly 3 cycles after accept; op 4'hF -> rsp_flags[0] mirrors the ALU's invalid-op flag.
